codemem_loader: RTL and testbench

//  Write-side front end for the BPF code memory. Accepts a program as a stream of
//  32-bit halves from the host, packs each pair into one 64-bit instruction and

---
 rtl/codemem_loader_if.sv | 29 ++
 rtl/codemem_loader.sv | 151 +++++++++++++++
 tb/tb_codemem_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/codemem_loader_if.sv
// Host stream and code RAM write port bundle for codemem_loader.
interface codemem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IN_WIDTH   = 32
);
  logic [IN_WIDTH-1:0]   s_data;
  logic                  s_valid;
  logic                  s_last;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  wr_clk_en;

  // Host side: drives the instruction-half stream, observes the write port.
  modport master (
    output s_data, s_valid, s_last,
    input  s_ready,
    input  wr_addr, wr_data, wr_en, wr_clk_en
  );

  // Loader side: consumes the stream, drives the code RAM write port.
  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready,
    output wr_addr, wr_data, wr_en, wr_clk_en
  );
endinterface

// File: rtl/codemem_loader.sv
// Packs pairs of 32-bit halves into 64-bit BPF instructions and writes them
// to the code RAM at sequential addresses from 0.
module codemem_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned IN_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  codemem_loader_if.slave     bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_WIDTH:0] inst_count,
  output logic                err_overflow,
  output logic                err_protocol
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_UP = 2'd1,
    WAIT_LO = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   upper_q, upper_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  s_ready_q, s_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_proto_q, err_proto_d;
  logic                  xfer_c;
  logic                  full_c;

  assign xfer_c = bus.s_valid && s_ready_q;
  assign full_c = (count_q == CNT_WIDTH'(DEPTH));

  // Next-state, packing and write-port decode.
  always_comb begin
    state_d     = state_q;
    upper_d     = upper_q;
    count_d     = count_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    done_d      = done_q;
    err_ovf_d   = err_ovf_q;
    err_proto_d = err_proto_q;

    if (start) begin
      // New load wins over any stream activity in the same cycle.
      state_d     = WAIT_UP;
      upper_d     = '0;
      count_d     = '0;
      wr_addr_d   = '0;
      done_d      = 1'b0;
      err_ovf_d   = 1'b0;
      err_proto_d = 1'b0;
    end else begin
      unique case (state_q)
        WAIT_UP: begin
          if (xfer_c) begin
            if (bus.s_last) begin
              // Program ended on an upper half: drop it and flag.
              err_proto_d = 1'b1;
              done_d      = 1'b1;
              state_d     = DONE;
            end else begin
              upper_d = bus.s_data;
              state_d = WAIT_LO;
            end
          end
        end
        WAIT_LO: begin
          if (xfer_c) begin
            if (full_c) begin
              // Keep draining the stream but discard the instruction.
              err_ovf_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = count_q[ADDR_WIDTH-1:0];
              wr_data_d = DATA_WIDTH'({upper_q, bus.s_data});
              count_d   = count_q + CNT_WIDTH'(1);
            end
            if (bus.s_last) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = WAIT_UP;
            end
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    s_ready_d = (state_d == WAIT_UP) || (state_d == WAIT_LO);
    busy_d    = s_ready_d;
  end

  // State and output registers; reset aborts any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      upper_q     <= '0;
      count_q     <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      upper_q     <= upper_d;
      count_q     <= count_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_ovf_q   <= err_ovf_d;
      err_proto_q <= err_proto_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_clk_en = wr_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign inst_count    = count_q;
  assign err_overflow  = err_ovf_q;
  assign err_protocol  = err_proto_q;

endmodule

// File: tb/tb_codemem_loader.sv
// Scoreboard bench for codemem_loader: a full-size instance and a 4-deep one.
module tb_codemem_loader;

  localparam int unsigned AW  = 10;
  localparam int unsigned AWS = 2;
  localparam int unsigned IW  = 32;
  localparam int unsigned DW  = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic start_l, start_s;
  logic [IW-1:0] drv_data;
  logic drv_valid, drv_last;

  logic busy_l, done_l, erro_l, errp_l;
  logic busy_s, done_s, erro_s, errp_s;
  logic [AW:0]  cnt_l;
  logic [AWS:0] cnt_s;

  always #5 clk = ~clk;

  codemem_loader_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW), .IN_WIDTH(IW)) bus ();
  codemem_loader_if #(.ADDR_WIDTH(AWS), .DATA_WIDTH(DW), .IN_WIDTH(IW)) bus_s ();

  assign bus.s_data    = drv_data;
  assign bus.s_valid   = drv_valid;
  assign bus.s_last    = drv_last;
  assign bus_s.s_data  = drv_data;
  assign bus_s.s_valid = drv_valid;
  assign bus_s.s_last  = drv_last;

  codemem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IN_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_l), .bus(bus),
    .busy(busy_l), .done(done_l), .inst_count(cnt_l),
    .err_overflow(erro_l), .err_protocol(errp_l)
  );

  codemem_loader #(.ADDR_WIDTH(AWS), .DATA_WIDTH(DW), .IN_WIDTH(IW)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .bus(bus_s),
    .busy(busy_s), .done(done_s), .inst_count(cnt_s),
    .err_overflow(erro_s), .err_protocol(errp_s)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_l[$];
  wr_t exp_s[$];
  int  vectors    = 0;
  int  miscompares = 0;
  int  wr_seen_l  = 0;
  int  wr_seen_s  = 0;
  int  accepted   = 0;

  // Reference model of the loader currently targeted (sel=0 big, sel=1 small).
  int          sel;
  int unsigned m_cnt;
  logic        m_lo, m_done, m_erro, m_errp;
  logic [IW-1:0] m_upper;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write-port monitor for the full-size loader.
  always @(negedge clk) begin
    wr_t e;
    if (bus.wr_clk_en !== bus.wr_en) check_eq("wr_clk_en", 64'(bus.wr_clk_en), 64'(bus.wr_en));
    if (bus.wr_en === 1'b1) begin
      wr_seen_l++;
      if (exp_l.size() == 0) begin
        check_eq("wr_unexpected", 64'(bus.wr_en), 64'(0));
      end else begin
        e = exp_l.pop_front();
        check_eq("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
        check_eq("wr_data", bus.wr_data, e.data);
      end
    end
  end

  // Write-port monitor for the 4-deep loader.
  always @(negedge clk) begin
    wr_t e;
    if (bus_s.wr_clk_en !== bus_s.wr_en) check_eq("wr_clk_en_s", 64'(bus_s.wr_clk_en), 64'(bus_s.wr_en));
    if (bus_s.wr_en === 1'b1) begin
      wr_seen_s++;
      if (exp_s.size() == 0) begin
        check_eq("wr_unexpected_s", 64'(bus_s.wr_en), 64'(0));
      end else begin
        e = exp_s.pop_front();
        check_eq("wr_addr_s", 64'(bus_s.wr_addr), 64'(e.addr));
        check_eq("wr_data_s", bus_s.wr_data, e.data);
      end
    end
  end

  function automatic logic cur_ready();
    return (sel != 0) ? bus_s.s_ready : bus.s_ready;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_lo = 1'b0; m_done = 1'b0; m_erro = 1'b0; m_errp = 1'b0; m_upper = '0;
    accepted = 0;
  endtask

  // Pulse start with junk on the stream, which the loader must ignore.
  task automatic start_load(input int which);
    sel = which;
    @(negedge clk);
    if (which != 0) start_s = 1'b1; else start_l = 1'b1;
    drv_valid = 1'b1; drv_data = 32'hDEAD_BEEF; drv_last = 1'b1;
    @(negedge clk);
    start_l = 1'b0; start_s = 1'b0;
    drv_valid = 1'b0; drv_last = 1'b0;
    model_clear();
  endtask

  // Present one half-word, wait for acceptance, update the model.
  task automatic send_word(input logic [IW-1:0] d, input logic last);
    wr_t e;
    int unsigned depth;
    depth = (sel != 0) ? (1 << AWS) : (1 << AW);
    @(negedge clk);
    drv_data = d; drv_valid = 1'b1; drv_last = last;
    for (int t = 0; !cur_ready(); t++) begin
      if (t >= 100) begin
        check_eq("ready_timeout", 64'(cur_ready()), 64'(1));
        drv_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 drv_valid = 1'b0;
    accepted++;
    if (!m_lo) begin
      if (last) begin m_errp = 1'b1; m_done = 1'b1; end
      else begin m_upper = d; m_lo = 1'b1; end
    end else begin
      if (m_cnt < depth) begin
        e.addr = AW'(m_cnt);
        e.data = {m_upper, d};
        if (sel != 0) exp_s.push_back(e); else exp_l.push_back(e);
        m_cnt++;
      end else begin
        m_erro = 1'b1;
      end
      if (last) m_done = 1'b1;
      m_lo = 1'b0;
    end
  endtask

  task automatic send_inst(input logic [IW-1:0] up, input logic [IW-1:0] lo,
                           input logic last, input logic gaps);
    if (gaps && ($urandom_range(0, 1) == 1)) repeat ($urandom_range(1, 3)) @(negedge clk);
    send_word(up, 1'b0);
    if (gaps && ($urandom_range(0, 1) == 1)) repeat ($urandom_range(1, 3)) @(negedge clk);
    send_word(lo, last);
  endtask

  task automatic final_check(input string tag);
    repeat (3) @(negedge clk);
    if (sel != 0) begin
      check_eq({tag, "_cnt"},  64'(cnt_s),  64'(m_cnt));
      check_eq({tag, "_done"}, 64'(done_s), 64'(m_done));
      check_eq({tag, "_busy"}, 64'(busy_s), 64'(!m_done));
      check_eq({tag, "_erro"}, 64'(erro_s), 64'(m_erro));
      check_eq({tag, "_errp"}, 64'(errp_s), 64'(m_errp));
      check_eq({tag, "_pend"}, 64'(exp_s.size()), 64'(0));
    end else begin
      check_eq({tag, "_cnt"},  64'(cnt_l),  64'(m_cnt));
      check_eq({tag, "_done"}, 64'(done_l), 64'(m_done));
      check_eq({tag, "_busy"}, 64'(busy_l), 64'(!m_done));
      check_eq({tag, "_erro"}, 64'(erro_l), 64'(m_erro));
      check_eq({tag, "_errp"}, 64'(errp_l), 64'(m_errp));
      check_eq({tag, "_pend"}, 64'(exp_l.size()), 64'(0));
    end
  endtask

  task automatic check_rst();
    check_eq("rst_data", bus.wr_data, 64'(0));
    check_eq("rst_misc", 64'({bus.s_ready, bus.wr_en, bus.wr_clk_en, busy_l, done_l,
                              erro_l, errp_l, bus.wr_addr, cnt_l}), 64'(0));
    check_eq("rst_misc_s", 64'({bus_s.s_ready, bus_s.wr_en, bus_s.wr_clk_en, busy_s, done_s,
                                erro_s, errp_s, bus_s.wr_addr, cnt_s}), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int saved;
    int k;
    rst_n = 1'b0; start_l = 1'b0; start_s = 1'b0;
    drv_data = '0; drv_valid = 1'b0; drv_last = 1'b0;
    sel = 0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rst();
    rst_n = 1'b1;

    // Reset asserted at random points mid-stream.
    for (int trial = 0; trial < 3; trial++) begin
      start_load(0);
      k = $urandom_range(1, 9);
      for (int i = 0; i < k; i++) send_word(IW'(32'h5000_0000 + i), 1'b0);
      @(posedge clk);
      #($urandom_range(1, 4));
      rst_n = 1'b0;
      exp_l.delete();
      @(negedge clk);
      check_rst();
      drv_valid = 1'b1; drv_last = 1'b0;
      saved = wr_seen_l;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check_eq("no_wr_after_rst", 64'(wr_seen_l), 64'(saved));
      check_eq("ready_after_rst", 64'(bus.s_ready), 64'(0));
      drv_valid = 1'b0;
    end

    // 16 instructions back-to-back.
    start_load(0);
    for (int i = 1; i <= 16; i++) send_inst(IW'(32'hA000_0000 + i), IW'(i), i == 16, 1'b0);
    final_check("b2b");

    // Same program with random valid gaps.
    start_load(0);
    saved = wr_seen_l;
    for (int i = 1; i <= 16; i++) send_inst(IW'(32'hA000_0000 + i), IW'(i), i == 16, 1'b1);
    final_check("gaps");
    check_eq("gaps_wr_count", 64'(wr_seen_l - saved), 64'(16));

    // s_last on an upper half.
    start_load(0);
    for (int i = 0; i < 3; i++) send_inst(IW'(32'hB000_0000 + i), IW'(32'h100 + i), 1'b0, 1'b0);
    send_word(32'hBBBB_0000, 1'b1);
    final_check("proto");

    // Restart mid-load: addresses resume at 0, errors clear.
    start_load(0);
    for (int i = 0; i < 3; i++) send_inst(IW'(32'hC000_0000 + i), IW'(32'h200 + i), 1'b0, 1'b0);
    start_load(0);
    for (int i = 0; i < 2; i++) send_inst(IW'(32'hD000_0000 + i), IW'(32'h300 + i), i == 1, 1'b0);
    final_check("restart");

    // Overflow on the 4-deep instance.
    start_load(1);
    for (int i = 0; i < 5; i++) send_inst(IW'(32'hE000_0000 + i), IW'(32'h400 + i), i == 4, 1'b0);
    final_check("ovf");
    check_eq("ovf_accepted", 64'(accepted), 64'(10));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
